// File: rtl/add_accum_ctrl.sv
// Accumulates a valid/ready operand stream through an external adder and presents sum/overflow/count.
// Result valid the cycle after the last beat is accepted; input stalls while a result waits for out_ready.
module add_accum_ctrl #(
  parameter int N       = 4,
  parameter int COUNT_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [N-1:0]       in_data,
  input  logic               in_last,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [N-1:0]       out_sum,
  output logic               out_overflow,
  output logic [COUNT_W-1:0] out_count,
  output logic [N-1:0]       add_a,
  output logic [N-1:0]       add_b,
  output logic               add_cin,
  input  logic [N-1:0]       add_sum,
  input  logic               add_cout
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [N-1:0]         acc_q, acc_d;
  logic                 ovf_q, ovf_d;
  logic [COUNT_W-1:0]   cnt_q, cnt_d;
  logic                 in_xfer;
  logic                 out_xfer;

  assign in_ready     = (state_q != DONE);
  assign out_valid    = (state_q == DONE);
  assign in_xfer      = in_valid & in_ready;
  assign out_xfer     = out_valid & out_ready;

  assign out_sum      = acc_q;
  assign out_overflow = ovf_q;
  assign out_count    = cnt_q;

  // The adder always sees the running total plus whatever sits on the input bus.
  assign add_a        = acc_q;
  assign add_b        = in_data;
  assign add_cin      = 1'b0;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE, ACCUM: begin
        if (in_xfer) begin
          acc_d = add_sum;
          ovf_d = ovf_q | add_cout;
          if (cnt_q != {COUNT_W{1'b1}}) begin
            cnt_d = cnt_q + COUNT_W'(1);
          end
          state_d = in_last ? DONE : ACCUM;
        end
      end
      DONE: begin
        if (out_xfer) begin
          acc_d   = '0;
          ovf_d   = 1'b0;
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_add_accum_ctrl.sv
// Bench for add_accum_ctrl: directed scenarios plus randomized traffic against a group-level model.
module tb_add_accum_ctrl;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic [3:0] in_data;
  logic       in_last;
  logic       out_ready;

  // Main instance (COUNT_W=4)
  logic       in_ready, out_valid, out_overflow, add_cin, add_cout;
  logic [3:0] out_sum, out_count, add_a, add_b, add_sum;

  // Saturation instance (COUNT_W=2), fed the same stimulus
  logic       s_in_ready, s_out_valid, s_out_overflow, s_add_cin, s_add_cout;
  logic [3:0] s_out_sum, s_add_a, s_add_b, s_add_sum;
  logic [1:0] s_out_count;

  int total = 0;
  int bad   = 0;

  // Model: beats accepted in the current group, and whether a result is pending
  int beats[$];
  bit m_done;

  logic [10:0] obs;
  assign obs = {in_ready, out_valid, out_sum, out_overflow, out_count};

  // External combinational adders
  assign {add_cout, add_sum}     = {1'b0, add_a} + {1'b0, add_b} + {4'b0000, add_cin};
  assign {s_add_cout, s_add_sum} = {1'b0, s_add_a} + {1'b0, s_add_b} + {4'b0000, s_add_cin};

  add_accum_ctrl #(.N(4), .COUNT_W(4)) u_dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
    .out_overflow(out_overflow), .out_count(out_count),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_sum(add_sum), .add_cout(add_cout)
  );

  add_accum_ctrl #(.N(4), .COUNT_W(2)) u_sat (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(s_in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(s_out_valid), .out_ready(out_ready), .out_sum(s_out_sum),
    .out_overflow(s_out_overflow), .out_count(s_out_count),
    .add_a(s_add_a), .add_b(s_add_b), .add_cin(s_add_cin),
    .add_sum(s_add_sum), .add_cout(s_add_cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int grp_total();
    int t = 0;
    foreach (beats[i]) t += beats[i];
    return t;
  endfunction

  // {in_ready, out_valid, sum mod 16, any wrap, saturated count}
  function automatic logic [10:0] exp_vec();
    int t = grp_total();
    int c = (beats.size() > 15) ? 15 : beats.size();
    logic [3:0] s4 = 4'(t % 16);
    logic [3:0] c4 = 4'(c);
    return {~m_done, m_done, s4, (t >= 16), c4};
  endfunction

  function automatic logic [1:0] exp_sat_cnt();
    int c = (beats.size() > 3) ? 3 : beats.size();
    return 2'(c);
  endfunction

  // Advance one clock edge and update the model from the inputs seen at that edge.
  task automatic tick();
    bit take_in  = in_valid && !m_done;
    bit take_out = m_done && out_ready;
    int d        = int'(in_data);
    bit l        = in_last;
    @(posedge clk);
    #1;
    if (take_out) begin
      m_done = 1'b0;
      beats.delete();
    end else if (take_in) begin
      beats.push_back(d);
      if (l) m_done = 1'b1;
    end
  endtask

  task automatic drive(input bit v, input int d, input bit l, input bit r);
    in_valid  = v;
    in_data   = 4'(d);
    in_last   = l;
    out_ready = r;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(0, 0, 0, 0);
    beats.delete();
    m_done = 1'b0;
    #2;
    total++;
    if (obs !== 11'b10_0000_0_0000) begin
      bad++;
      $display("FAIL reset_state: got %h want %h", obs, 11'b10_0000_0_0000);
    end
    @(negedge clk);
    rst = 1'b0;
    tick();
    total++;
    if (obs !== exp_vec()) begin
      bad++;
      $display("FAIL reset_idle: got %h want %h", obs, exp_vec());
    end
  endtask

  task automatic test_basic_sum();
    int d[3] = '{3, 5, 6};
    for (int i = 0; i < 3; i++) begin
      drive(1, d[i], i == 2, 0);
      tick();
      total++;
      if (obs !== exp_vec()) begin
        bad++;
        $display("FAIL basic_beat%0d: got %h want %h", i, obs, exp_vec());
      end
    end
    drive(0, 0, 0, 0);
    total++;
    if ({out_valid, out_sum, out_overflow, out_count} !== {1'b1, 4'd14, 1'b0, 4'd3}) begin
      bad++;
      $display("FAIL basic_result: got v=%0b s=%0d o=%0b c=%0d want 1/14/0/3",
               out_valid, out_sum, out_overflow, out_count);
    end
    drive(0, 0, 0, 1);
    tick();
    total++;
    if (obs !== exp_vec() || !in_ready) begin
      bad++;
      $display("FAIL basic_drain: got %h want %h", obs, exp_vec());
    end
    drive(0, 0, 0, 0);
  endtask

  task automatic test_wrap();
    drive(1, 9, 0, 0); tick();
    drive(1, 8, 1, 0); tick();
    drive(0, 0, 0, 0);
    total++;
    if ({out_valid, out_sum, out_overflow, out_count} !== {1'b1, 4'd1, 1'b1, 4'd2}) begin
      bad++;
      $display("FAIL wrap_result: got v=%0b s=%0d o=%0b c=%0d want 1/1/1/2",
               out_valid, out_sum, out_overflow, out_count);
    end
    drive(0, 0, 0, 1); tick();
    drive(1, 2, 1, 0); tick();
    drive(0, 0, 0, 0);
    total++;
    if ({out_valid, out_sum, out_overflow, out_count} !== {1'b1, 4'd2, 1'b0, 4'd1}) begin
      bad++;
      $display("FAIL wrap_next_group: got v=%0b s=%0d o=%0b c=%0d want 1/2/0/1",
               out_valid, out_sum, out_overflow, out_count);
    end
    drive(0, 0, 0, 1); tick();
    drive(0, 0, 0, 0);
  endtask

  task automatic test_backpressure();
    drive(1, 7, 1, 0); tick();
    drive(1, 15, 0, 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      total++;
      if ({in_ready, out_valid, out_sum, out_overflow, out_count} !== {1'b0, 1'b1, 4'd7, 1'b0, 4'd1}) begin
        bad++;
        $display("FAIL bp_hold%0d: got %h want %h", i, obs, {1'b0, 1'b1, 4'd7, 1'b0, 4'd1});
      end
    end
    out_ready = 1'b1;
    tick();
    total++;
    if ({in_ready, out_valid, out_count} !== {1'b1, 1'b0, 4'd0}) begin
      bad++;
      $display("FAIL bp_release: got rdy=%0b v=%0b c=%0d want 1/0/0", in_ready, out_valid, out_count);
    end
    out_ready = 1'b0;
    tick();
    total++;
    if ({out_sum, out_count} !== {4'd15, 4'd1} || obs !== exp_vec()) begin
      bad++;
      $display("FAIL bp_held_beat: got s=%0d c=%0d want 15/1", out_sum, out_count);
    end
    drive(1, 1, 1, 0); tick();
    drive(0, 0, 0, 0);
    total++;
    if ({out_sum, out_overflow, out_count} !== {4'd0, 1'b1, 4'd2}) begin
      bad++;
      $display("FAIL bp_group2: got s=%0d o=%0b c=%0d want 0/1/2", out_sum, out_overflow, out_count);
    end
    drive(0, 0, 0, 1); tick();
    drive(0, 0, 0, 0);
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 5; i++) begin
      drive(1, 1, i == 4, 0);
      tick();
    end
    drive(0, 0, 0, 0);
    total++;
    if ({s_out_valid, s_out_count, s_out_sum, s_out_overflow} !== {1'b1, 2'd3, 4'd5, 1'b0}) begin
      bad++;
      $display("FAIL sat_cw2: got v=%0b c=%0d s=%0d o=%0b want 1/3/5/0",
               s_out_valid, s_out_count, s_out_sum, s_out_overflow);
    end
    total++;
    if (out_count !== 4'd5) begin
      bad++;
      $display("FAIL sat_cw4_unsat: got %0d want 5", out_count);
    end
    drive(0, 0, 0, 1); tick();
    for (int i = 0; i < 18; i++) begin
      drive(1, 1, i == 17, 0);
      tick();
    end
    drive(0, 0, 0, 0);
    total++;
    if ({out_count, out_sum, out_overflow} !== {4'd15, 4'd2, 1'b1} || obs !== exp_vec()) begin
      bad++;
      $display("FAIL sat_cw4: got c=%0d s=%0d o=%0b want 15/2/1", out_count, out_sum, out_overflow);
    end
    drive(0, 0, 0, 1); tick();
    drive(0, 0, 0, 0);
  endtask

  task automatic test_reset_mid();
    drive(1, 4, 0, 0); tick();
    tick();
    drive(0, 0, 0, 0);
    #2;
    rst = 1'b1;
    beats.delete();
    m_done = 1'b0;
    #1;
    total++;
    if (obs !== 11'b10_0000_0_0000 || s_out_count !== 2'd0) begin
      bad++;
      $display("FAIL reset_mid: got %h want %h", obs, 11'b10_0000_0_0000);
    end
    #2;
    rst = 1'b0;
    drive(1, 3, 1, 0); tick();
    drive(0, 0, 0, 0);
    total++;
    if ({out_valid, out_sum, out_count} !== {1'b1, 4'd3, 4'd1}) begin
      bad++;
      $display("FAIL reset_mid_next: got v=%0b s=%0d c=%0d want 1/3/1", out_valid, out_sum, out_count);
    end
    drive(0, 0, 0, 1); tick();
    drive(0, 0, 0, 0);
  endtask

  task automatic test_gaps();
    int d[5]   = '{1, 0, 2, 0, 4};
    bit vld[5] = '{1, 0, 1, 0, 1};
    for (int i = 0; i < 5; i++) begin
      drive(vld[i], d[i], i == 4, 1);
      tick();
    end
    drive(0, 0, 0, 1);
    total++;
    if ({out_valid, out_sum, out_overflow, out_count} !== {1'b1, 4'd7, 1'b0, 4'd3}) begin
      bad++;
      $display("FAIL gaps_result: got v=%0b s=%0d o=%0b c=%0d want 1/7/0/3",
               out_valid, out_sum, out_overflow, out_count);
    end
    tick();
    total++;
    if ({out_valid, in_ready} !== 2'b01) begin
      bad++;
      $display("FAIL gaps_pulse: got v=%0b rdy=%0b want 0/1", out_valid, in_ready);
    end
    drive(0, 0, 0, 0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 15),
            $urandom_range(0, 5) == 0, $urandom_range(0, 2) != 0);
      #1;
      total++;
      if (add_a !== 4'(grp_total() % 16) || add_b !== in_data || add_cin !== 1'b0) begin
        bad++;
        $display("FAIL rand_adder_ports%0d: got a=%0d b=%0d cin=%0b want %0d/%0d/0",
                 i, add_a, add_b, add_cin, grp_total() % 16, in_data);
      end
      tick();
      total++;
      if (obs !== exp_vec() || s_out_count !== exp_sat_cnt()) begin
        bad++;
        $display("FAIL rand_cycle%0d: got %h/%0d want %h/%0d",
                 i, obs, s_out_count, exp_vec(), exp_sat_cnt());
      end
    end
    drive(0, 0, 0, 0);
  endtask

  initial begin
    test_reset();
    test_basic_sum();
    test_wrap();
    test_backpressure();
    test_saturation();
    test_reset_mid();
    test_gaps();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
